// File: rtl/uart_tx_param.sv
// uart_tx_param -- parameterised UART transmitter.
//
// Sends one frame per accepted payload: start bit (0), DATA_W payload bits
// LSB first, optional parity bit, then one or two stop bits (1). Every bit
// lasts max(baud_div,1) clk cycles. All frame settings are captured when the
// payload is accepted, so the inputs may change freely during a frame.
//
// Build option: define UART_TX_HOLD_EN to add a one-entry holding register
// that lets a second payload be accepted while a frame is on the line; the
// next frame then starts with no idle gap. Without it, data_ready is only
// high in IDLE and back-to-back frames are separated by one idle-high clk.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   parallel_data  payload (DATA_W bits, LSB transmitted first)
//   data_valid     payload offered this cycle
//   data_ready     payload can be accepted this cycle
//   parity_EN      append a parity bit
//   parity_type    0 = even, 1 = odd
//   stop2          0 = one stop bit, 1 = two stop bits
//   baud_div       clk cycles per bit (0 behaves as 1)
//   TX_OUT         registered serial output, idle high
//   Busy           high from the first start-bit cycle to the last stop-bit cycle

module uart_tx_param #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] parallel_data,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              parity_EN,
  input  logic              parity_type,
  input  logic              stop2,
  input  logic [DIV_W-1:0]  baud_div,
  output logic              TX_OUT,
  output logic              Busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]        r_state;
  logic              r_tx;
  logic [DIV_W-1:0]  r_baud_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic              r_par_en;
  logic              r_stop2;
  logic              r_stop_more;   // a second stop bit still follows

  logic              w_bit_end;
  logic              w_frame_end;
  logic              w_accept;
  logic              w_ready;
  logic              w_load_new;    // start a frame from the input port
  logic              w_load_hold;   // start a frame from the holding register
  logic              w_load;
  logic [DATA_W-1:0] w_src_data;
  logic              w_src_par_en;
  logic              w_src_par;
  logic              w_src_stop2;
  logic [DIV_W-1:0]  w_src_div;
  logic [DIV_W-1:0]  w_src_div_eff;

`ifdef UART_TX_HOLD_EN
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_hold_par_en;
  logic              r_hold_par;
  logic              r_hold_stop2;
  logic [DIV_W-1:0]  r_hold_div;
  logic              w_hold_wr;
`endif

  always_comb begin
    w_bit_end   = (r_baud_cnt == '0);
    // Frame ends on the last cycle of the final stop bit.
    w_frame_end = (r_state == STOP) && w_bit_end && !r_stop_more;
`ifdef UART_TX_HOLD_EN
    w_ready     = !r_hold_full;
`else
    w_ready     = (r_state == IDLE);
`endif
    // Reset gates the handshake so nothing is accepted on a reset edge.
    data_ready  = w_ready && !rst;
    w_accept    = data_valid && data_ready;
`ifdef UART_TX_HOLD_EN
    // A payload arriving exactly as a frame ends bypasses the register.
    w_load_new  = w_accept && ((r_state == IDLE) || w_frame_end);
    w_load_hold = w_frame_end && r_hold_full;
    w_hold_wr   = w_accept && !w_load_new;
`else
    w_load_new  = w_accept;
    w_load_hold = 1'b0;
`endif
    w_load      = w_load_new || w_load_hold;

    w_src_data   = parallel_data;
    w_src_par_en = parity_EN;
    w_src_par    = (^parallel_data) ^ parity_type;
    w_src_stop2  = stop2;
    w_src_div    = baud_div;
`ifdef UART_TX_HOLD_EN
    if (w_load_hold) begin
      w_src_data   = r_hold_data;
      w_src_par_en = r_hold_par_en;
      w_src_par    = r_hold_par;
      w_src_stop2  = r_hold_stop2;
      w_src_div    = r_hold_div;
    end
`endif
    w_src_div_eff = (w_src_div == '0) ? DIV_W'(1) : w_src_div;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tx        <= 1'b1;
      r_baud_cnt  <= '0;
      r_div       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_par_en    <= 1'b0;
      r_stop2     <= 1'b0;
      r_stop_more <= 1'b0;
    end else if (w_load) begin
      r_state     <= START;
      r_tx        <= 1'b0;
      r_div       <= w_src_div_eff;
      r_baud_cnt  <= w_src_div_eff - DIV_W'(1);
      r_bit_cnt   <= '0;
      r_shift     <= w_src_data;
      r_parity    <= w_src_par;
      r_par_en    <= w_src_par_en;
      r_stop2     <= w_src_stop2;
      r_stop_more <= 1'b0;
    end else if (r_state != IDLE) begin
      if (!w_bit_end) begin
        r_baud_cnt <= r_baud_cnt - DIV_W'(1);
      end else begin
        r_baud_cnt <= r_div - DIV_W'(1);
        case (r_state)
          START: begin
            r_state   <= DATA;
            r_tx      <= r_shift[0];
            r_bit_cnt <= '0;
          end
          DATA: begin
            if (r_bit_cnt == LAST_BIT) begin
              if (r_par_en) begin
                r_state <= PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state     <= STOP;
                r_tx        <= 1'b1;
                r_stop_more <= r_stop2;
              end
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
          PARITY: begin
            r_state     <= STOP;
            r_tx        <= 1'b1;
            r_stop_more <= r_stop2;
          end
          STOP: begin
            r_tx <= 1'b1;
            if (r_stop_more) begin
              r_stop_more <= 1'b0;
            end else begin
              r_state    <= IDLE;
              r_baud_cnt <= '0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef UART_TX_HOLD_EN
  // Write and drain are exclusive: a write needs the register empty,
  // a drain needs it full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_full   <= 1'b0;
      r_hold_data   <= '0;
      r_hold_par_en <= 1'b0;
      r_hold_par    <= 1'b0;
      r_hold_stop2  <= 1'b0;
      r_hold_div    <= '0;
    end else if (w_hold_wr) begin
      r_hold_full   <= 1'b1;
      r_hold_data   <= parallel_data;
      r_hold_par_en <= parity_EN;
      r_hold_par    <= (^parallel_data) ^ parity_type;
      r_hold_stop2  <= stop2;
      r_hold_div    <= baud_div;
    end else if (w_load_hold) begin
      r_hold_full   <= 1'b0;
    end
  end
`endif

  assign TX_OUT = r_tx;
  assign Busy   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;
  localparam int DW = 8;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] parallel_data = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic          parity_EN = 1'b0;
  logic          parity_type = 1'b0;
  logic          stop2 = 1'b0;
  logic [VW-1:0] baud_div = 16'd1;
  logic          TX_OUT;
  logic          Busy;

  int tests = 0;
  int failed = 0;

  logic cap_tx   [1024];
  logic cap_busy [1024];
  bit   exp_tx   [1024];
  bit   exp_busy [1024];

  uart_tx_param #(.DATA_W(DW), .DIV_W(VW)) dut (
    .clk(clk), .rst(rst), .parallel_data(parallel_data), .data_valid(data_valid),
    .data_ready(data_ready), .parity_EN(parity_EN), .parity_type(parity_type),
    .stop2(stop2), .baud_div(baud_div), .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a list of line levels, each stretched to
  // max(div,1) cycles during which Busy is high.
  function automatic int model_frame(input int idx, input logic [DW-1:0] d, input bit pe,
                                     input bit pt, input bit s2, input int div);
    bit bits[$];
    int eff;
    bits.push_back(1'b0);
    for (int j = 0; j < DW; j++) bits.push_back(d[j]);
    if (pe) bits.push_back((($countones(d) % 2) == 1) ^ pt);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    eff = (div == 0) ? 1 : div;
    foreach (bits[k]) begin
      for (int r = 0; r < eff; r++) begin
        exp_tx[idx]   = bits[k];
        exp_busy[idx] = 1'b1;
        idx++;
      end
    end
    return idx;
  endfunction

  function automatic int model_idle(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx[idx]   = 1'b1;
      exp_busy[idx] = 1'b0;
      idx++;
    end
    return idx;
  endfunction

  function automatic int diff_tx(input int n);
    for (int i = 0; i < n; i++) if (cap_tx[i] !== exp_tx[i]) return i;
    return -1;
  endfunction

  function automatic int diff_busy(input int n);
    for (int i = 0; i < n; i++) if (cap_busy[i] !== exp_busy[i]) return i;
    return -1;
  endfunction

  function automatic int busy_count(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (cap_busy[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic drive(input logic [DW-1:0] d, input bit pe, input bit pt, input bit s2,
                       input int div);
    parallel_data = d;
    parity_EN     = pe;
    parity_type   = pt;
    stop2         = s2;
    baud_div      = VW'(div);
  endtask

  // Offers the driven payload and returns just after the accepting edge.
  task automatic accept(output bit ok);
    ok = 1'b0;
    data_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (data_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_tx[i]   = TX_OUT;
      cap_busy[i] = Busy;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (data_ready !== 1'b0) begin failed++; $display("FAIL reset_ready: got %b expected 0", data_ready); end
    tests++; if (TX_OUT !== 1'b1) begin failed++; $display("FAIL reset_tx: got %b expected 1", TX_OUT); end
    tests++; if (Busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    tests++; if (data_ready !== 1'b1) begin failed++; $display("FAIL post_reset_ready: got %b expected 1", data_ready); end
    $display("[TB] reset: ready=%b tx=%b busy=%b", data_ready, TX_OUT, Busy);
  endtask

  task automatic test_basic();
    bit ok; int n, d;
    drive(8'hA5, 0, 0, 0, 4);
    accept(ok);
    tests++; if (!ok) begin failed++; $display("FAIL basic_accept: got timeout expected acceptance"); end
    n = model_idle(model_frame(0, 8'hA5, 0, 0, 0, 4), 2);
    capture(n);
    d = diff_tx(n);
    tests++; if (d >= 0) begin failed++; $display("FAIL basic_tx cycle %0d: got %b expected %b", d, cap_tx[d], exp_tx[d]); end
    d = busy_count(n);
    tests++; if (d != 40) begin failed++; $display("FAIL basic_busy_len: got %0d expected 40", d); end
    d = diff_busy(n);
    tests++; if (d >= 0) begin failed++; $display("FAIL basic_busy cycle %0d: got %b expected %b", d, cap_busy[d], exp_busy[d]); end
    $display("[TB] basic frame 0xA5 div=4 checked over %0d cycles", n);
  endtask

  task automatic test_parity();
    bit ok; int n, d;
    for (int pt = 0; pt < 2; pt++) begin
      drive(8'h07, 1, pt[0], 0, 3);
      accept(ok);
      tests++; if (!ok) begin failed++; $display("FAIL parity_accept: got timeout expected acceptance"); end
      n = model_idle(model_frame(0, 8'h07, 1, pt[0], 0, 3), 1);
      capture(n);
      tests++; if (cap_tx[27] !== (pt == 0 ? 1'b1 : 1'b0)) begin
        failed++; $display("FAIL parity_bit type=%0d: got %b expected %b", pt, cap_tx[27], (pt == 0 ? 1'b1 : 1'b0));
      end
      d = busy_count(n);
      tests++; if (d != 33) begin failed++; $display("FAIL parity_len type=%0d: got %0d expected 33", pt, d); end
      d = diff_tx(n);
      tests++; if (d >= 0) begin failed++; $display("FAIL parity_tx cycle %0d: got %b expected %b", d, cap_tx[d], exp_tx[d]); end
      $display("[TB] parity frame 0x07 type=%0d parity bit=%b", pt, cap_tx[27]);
    end
  endtask

  task automatic test_stop2_div0();
    bit ok; int n, d; logic [DW-1:0] dat;
    dat = DW'($urandom);
    drive(dat, 0, 0, 1, 0);
    accept(ok);
    tests++; if (!ok) begin failed++; $display("FAIL stop2_accept: got timeout expected acceptance"); end
    n = model_idle(model_frame(0, dat, 0, 0, 1, 0), 2);
    capture(n);
    d = busy_count(n);
    tests++; if (d != 11) begin failed++; $display("FAIL stop2_busy_len: got %0d expected 11", d); end
    d = diff_tx(n);
    tests++; if (d >= 0) begin failed++; $display("FAIL stop2_tx cycle %0d: got %b expected %b", d, cap_tx[d], exp_tx[d]); end
    $display("[TB] stop2 div=0 frame 0x%02h", dat);
  endtask

  task automatic test_midframe_change();
    bit ok, pt; int n, d; logic [DW-1:0] a, b;
    a = DW'($urandom); b = DW'($urandom); pt = 1'($urandom);
    drive(a, 0, 0, 0, 4);
    accept(ok);
    tests++; if (!ok) begin failed++; $display("FAIL midframe_accept_a: got timeout expected acceptance"); end
    baud_div = 16'd8; parity_EN = 1'b1; parity_type = pt; parallel_data = b;
    n = model_idle(model_frame(0, a, 0, 0, 0, 4), 1);
    capture(n);
    d = diff_tx(n);
    tests++; if (d >= 0) begin failed++; $display("FAIL midframe_old_tx cycle %0d: got %b expected %b", d, cap_tx[d], exp_tx[d]); end
    accept(ok);
    tests++; if (!ok) begin failed++; $display("FAIL midframe_accept_b: got timeout expected acceptance"); end
    n = model_idle(model_frame(0, b, 1, pt, 0, 8), 1);
    capture(n);
    d = diff_tx(n);
    tests++; if (d >= 0) begin failed++; $display("FAIL midframe_new_tx cycle %0d: got %b expected %b", d, cap_tx[d], exp_tx[d]); end
    d = diff_busy(n);
    tests++; if (d >= 0) begin failed++; $display("FAIL midframe_new_busy cycle %0d: got %b expected %b", d, cap_busy[d], exp_busy[d]); end
    $display("[TB] midframe change: 0x%02h div4 then 0x%02h div8 parity", a, b);
  endtask

  task automatic test_reset_midframe();
    bit ok; int n, d; logic [DW-1:0] dat;
    drive(8'hA5, 0, 0, 0, 4);
    accept(ok);
    tests++; if (!ok) begin failed++; $display("FAIL rstmid_accept: got timeout expected acceptance"); end
    capture(17);           // last sample is the first cycle of data bit 3
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    tests++; if (TX_OUT !== 1'b1) begin failed++; $display("FAIL rstmid_tx: got %b expected 1", TX_OUT); end
    tests++; if (Busy !== 1'b0) begin failed++; $display("FAIL rstmid_busy: got %b expected 0", Busy); end
    tests++; if (data_ready !== 1'b1) begin failed++; $display("FAIL rstmid_ready: got %b expected 1", data_ready); end
    n = model_idle(0, 12);
    capture(n);
    d = diff_tx(n);
    tests++; if (d >= 0) begin failed++; $display("FAIL rstmid_idle cycle %0d: got %b expected %b", d, cap_tx[d], exp_tx[d]); end
    dat = DW'($urandom);
    drive(dat, 1, 0, 0, 2);
    accept(ok);
    tests++; if (!ok) begin failed++; $display("FAIL rstmid_accept2: got timeout expected acceptance"); end
    n = model_idle(model_frame(0, dat, 1, 0, 0, 2), 1);
    capture(n);
    d = diff_tx(n);
    tests++; if (d >= 0) begin failed++; $display("FAIL rstmid_new_tx cycle %0d: got %b expected %b", d, cap_tx[d], exp_tx[d]); end
    $display("[TB] reset mid-frame, then clean frame 0x%02h", dat);
  endtask

  task automatic test_back_to_back();
    bit ok, ok2; int n, d; logic [DW-1:0] a, b;
    a = DW'($urandom); b = DW'($urandom);
    drive(a, 0, 0, 0, 2);
    accept(ok);
    tests++; if (!ok) begin failed++; $display("FAIL b2b_accept_a: got timeout expected acceptance"); end
    drive(b, 0, 0, 0, 2);
    n = model_frame(0, a, 0, 0, 0, 2);
`ifndef UART_TX_HOLD_EN
    n = model_idle(n, 1);
`endif
    n = model_idle(model_frame(n, b, 0, 0, 0, 2), 1);
    ok2 = 1'b0;
    fork
      capture(n);
      begin
        data_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (data_ready === 1'b1) begin
            @(posedge clk); #1;
            ok2 = 1'b1;
            break;
          end
        end
        data_valid = 1'b0;
      end
    join
    tests++; if (!ok2) begin failed++; $display("FAIL b2b_accept_b: got timeout expected acceptance"); end
    d = diff_tx(n);
    tests++; if (d >= 0) begin failed++; $display("FAIL b2b_tx cycle %0d: got %b expected %b", d, cap_tx[d], exp_tx[d]); end
    d = diff_busy(n);
    tests++; if (d >= 0) begin failed++; $display("FAIL b2b_busy cycle %0d: got %b expected %b", d, cap_busy[d], exp_busy[d]); end
    $display("[TB] back-to-back 0x%02h then 0x%02h over %0d cycles", a, b, n);
  endtask

  task automatic test_random();
    bit ok, pe, pt, s2; int n, d, div; logic [DW-1:0] dat;
    for (int k = 0; k < 8; k++) begin
      dat = DW'($urandom); pe = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
      div = int'($urandom_range(0, 5));
      drive(dat, pe, pt, s2, div);
      accept(ok);
      tests++; if (!ok) begin failed++; $display("FAIL rand_accept %0d: got timeout expected acceptance", k); end
      n = model_idle(model_frame(0, dat, pe, pt, s2, div), 1);
      capture(n);
      d = diff_tx(n);
      tests++; if (d >= 0) begin failed++; $display("FAIL rand_tx %0d cycle %0d: got %b expected %b", k, d, cap_tx[d], exp_tx[d]); end
      d = diff_busy(n);
      tests++; if (d >= 0) begin failed++; $display("FAIL rand_busy %0d cycle %0d: got %b expected %b", k, d, cap_busy[d], exp_busy[d]); end
      $display("[TB] random frame %0d: data=0x%02h pe=%0d pt=%0d s2=%0d div=%0d", k, dat, pe, pt, s2, div);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop2_div0();
    test_midframe_change();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DIV_W, default 16, width of the baud divisor input.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port parallel_data  input  DATA_W  frame payload, LSB sent first.
REQ-006 SHALL have port data_valid  input  1  payload offered this cycle.
REQ-007 SHALL have port data_ready  output  1  block can accept a payload this cycle.
REQ-008 SHALL have port parity_EN  input  1  append a parity bit.
REQ-009 SHALL have port parity_type  input  1  0 = even, 1 = odd.
REQ-010 SHALL have port stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 SHALL have port baud_div  input  DIV_W  clk cycles per bit; 0 is treated as 1.
REQ-012 SHALL have port TX_OUT  output  1  registered serial line, idle high.
REQ-013 SHALL have port Busy  output  1  frame in progress (start..last stop bit).

Function
REQ-014 SHALL accept a payload on a rising edge where data_valid and data_ready are both 1; no other edge transfers data.
REQ-015 SHALL sample parallel_data, parity_EN, parity_type, stop2 and baud_div at acceptance; later changes SHALL NOT affect that frame.
REQ-016 SHALL compute parity at acceptance: even = XOR of the payload bits; odd = its inverse.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE->START on acceptance.
- START->DATA after one bit time.
- DATA->PARITY after DATA_W bit times if parity enabled, else DATA->STOP.
- PARITY->STOP after one bit time.
- STOP->IDLE, or STOP->START when a payload is pending (see REQ-029).
REQ-018 SHALL hold each bit on TX_OUT for exactly max(baud_div,1) clk cycles, timed by a down-counter reloaded at every bit boundary.
REQ-019 SHALL drive TX_OUT = 0 in START, payload bit i in DATA bit slot i, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-020 SHALL drive the start bit on TX_OUT from the first cycle after the acceptance edge (latency 1 clk).
REQ-021 SHALL send 1 stop bit when stop2 = 0 and 2 stop bits when stop2 = 1.
REQ-022 SHALL make frame length (1 + DATA_W + parity_EN + 1 + stop2) x max(baud_div,1) cycles.
REQ-023 SHALL assert Busy from the first start-bit cycle through the last stop-bit cycle, and deassert it in IDLE.
REQ-024 SHALL count DATA bits with a counter of width clog2(DATA_W)+1, with no wrap inside a frame.
REQ-025 SHALL treat baud_div = 1 (or 0) as one clk per bit, with no extra cycles inserted.

Reset
REQ-026 SHALL, while rst = 1 at a clock edge, force state IDLE, TX_OUT = 1, Busy = 0, data_ready = 0, counters = 0, and holding register empty.
REQ-027 SHALL, on reset asserted mid-frame, abort the frame: TX_OUT = 1 the next cycle and no partial frame resumes; data_ready = 1 on the first cycle after rst falls.

Configuration
REQ-028 SHALL compile a one-entry holding register only when macro UART_TX_HOLD_EN is defined.
REQ-029 SHALL, with UART_TX_HOLD_EN defined:
- drive data_ready = 1 whenever the holding register is empty, including during a frame;
- when the final stop bit ends with the register full, go STOP->START on the next cycle with zero idle cycles;
- when acceptance and a frame ending coincide, send the new payload immediately and keep the register empty.
REQ-030 SHALL, without UART_TX_HOLD_EN:
- drive data_ready = 1 only in IDLE;
- make the minimum gap between back-to-back frames exactly one idle-high clk.

Verification
REQ-031 Reset, then DATA_W = 8, baud_div = 4, payload 0xA5, no parity, stop2 = 0 -> TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit 4 clks; Busy high for 40 clks.
REQ-032 Payload 0x07, parity_EN = 1, parity_type = 0 -> parity bit 1; with parity_type = 1 -> parity bit 0; frame 11 bits.
REQ-033 stop2 = 1, baud_div = 0 -> every bit 1 clk, two high stop cycles, Busy high for 11 clks.
REQ-034 Change baud_div from 4 to 8 and parity_EN mid-frame -> current frame unchanged; the next frame uses the new values.
REQ-035 Assert rst during DATA bit 3 -> next cycle TX_OUT = 1, Busy = 0; after release, a new frame starts cleanly.
REQ-036 Offer two payloads back-to-back, baud_div = 2 -> with UART_TX_HOLD_EN the second start bit directly follows the stop bit; without it there is exactly one idle clk between frames.
